// File: rtl/data_mem_io_bridge_if.sv
// CPU-side load/store bus between the EX/MEM stage and the data memory / I/O bridge.
interface data_mem_io_bridge_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    modport master (output Address, output WriteData, output MemWrite, output MemRead, input ReadData);
    modport slave  (input Address, input WriteData, input MemWrite, input MemRead, output ReadData);
endinterface

// File: rtl/data_mem_io_bridge.sv
// Address decoder steering CPU loads/stores to the data RAM or to a small I/O
// register block (output port, synchronised input port, free-running timer).
module data_mem_io_bridge #(
    parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    data_mem_io_bridge_if.slave          bus,
    input  logic [7:0]                   PortIn,
    input  logic [31:0]                  RamReadData,
    output logic [$clog2(RAM_WORDS)-1:0] RamAddress,
    output logic                         RamWrite,
    output logic                         RamRead,
    output logic [31:0]                  PortOut,
    output logic                         BusError
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0] ram_off_s, io_off_s, rdata_s, io_rdata_s;
    logic        ram_hit_s, io_hit_s, aligned_s, acc_err_s, io_wr_s, match_set_s;

    logic [31:0] out_q, out_d, count_q, count_d, compare_q, compare_d;
    logic        en_q, en_d, match_q, match_d, bus_err_q, bus_err_d;
    logic [7:0]  sync1_q, sync2_q;

    // Window decode: the subtraction wraps for addresses below a base, so a single unsigned compare suffices.
    always_comb begin
        ram_off_s = bus.Address - RAM_BASE;
        io_off_s  = bus.Address - IO_BASE;
        ram_hit_s = (ram_off_s < RAM_BYTES);
        io_hit_s  = (io_off_s < 32'd32);
        aligned_s = (bus.Address[1:0] == 2'b00);
        acc_err_s = (bus.MemRead | bus.MemWrite) & (~aligned_s | ~(ram_hit_s | io_hit_s));
        io_wr_s   = bus.MemWrite & aligned_s & io_hit_s;
    end

    assign RamAddress = ram_off_s[AW+1:2];
    assign RamWrite   = bus.MemWrite & aligned_s & ram_hit_s;
    assign RamRead    = bus.MemRead & aligned_s & ram_hit_s;

    // I/O register read mux.
    always_comb begin
        io_rdata_s = 32'd0;
        case (io_off_s[4:2])
            3'd0:    io_rdata_s = out_q;
            3'd1:    io_rdata_s = {24'd0, sync2_q};
            3'd2:    io_rdata_s = count_q;
            3'd3:    io_rdata_s = compare_q;
            3'd4:    io_rdata_s = {30'd0, match_q, en_q};
            default: io_rdata_s = 32'd0;
        endcase
    end

    // Load data: returned in the same cycle, zero for anything not a legal load.
    always_comb begin
        rdata_s = 32'd0;
        if (bus.MemRead && aligned_s && ram_hit_s) begin
            rdata_s = RamReadData;
        end else if (bus.MemRead && aligned_s && io_hit_s) begin
            rdata_s = io_rdata_s;
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.ReadData = rdata_s;

    // Register next-state: CPU writes beat the timer increment, a match set beats write-1-to-clear.
    always_comb begin
        out_d       = out_q;
        count_d     = count_q;
        compare_d   = compare_q;
        en_d        = en_q;
        match_d     = match_q;
        match_set_s = en_q && (count_q == compare_q);
        bus_err_d   = bus_err_q | acc_err_s;

        if (io_wr_s && io_off_s[4:2] == 3'd0) begin
            out_d = bus.WriteData;
        end else begin
            out_d = out_q;
        end

        if (io_wr_s && io_off_s[4:2] == 3'd2) begin
            count_d = bus.WriteData;
        end else if (en_q) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        if (io_wr_s && io_off_s[4:2] == 3'd3) begin
            compare_d = bus.WriteData;
        end else begin
            compare_d = compare_q;
        end

        if (io_wr_s && io_off_s[4:2] == 3'd4) begin
            en_d = bus.WriteData[0];
        end else begin
            en_d = en_q;
        end

        if (match_set_s) begin
            match_d = 1'b1;
        end else if (io_wr_s && io_off_s[4:2] == 3'd4 && bus.WriteData[1]) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= 32'd0;
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            en_q      <= 1'b0;
            match_q   <= 1'b0;
            bus_err_q <= 1'b0;
            sync1_q   <= 8'd0;
            sync2_q   <= 8'd0;
        end else begin
            out_q     <= out_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            en_q      <= en_d;
            match_q   <= match_d;
            bus_err_q <= bus_err_d;
            sync1_q   <= PortIn;
            sync2_q   <= sync1_q;
        end
    end

    assign PortOut  = out_q;
    assign BusError = bus_err_q;
endmodule

// File: tb/tb_data_mem_io_bridge.sv
// Scoreboard bench: the driver queues expected outputs tagged with the cycle they
// belong to; a negedge monitor pops and compares them.
module tb_data_mem_io_bridge;
    localparam logic [31:0] IO = 32'hFFFF_0000;
    localparam int SEL_RD = 0, SEL_PO = 1, SEL_BE = 2, SEL_RW = 3, SEL_RR = 4, SEL_RA = 5;

    typedef struct packed {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        int          tag;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] RamReadData;
    logic [9:0]  RamAddress;
    logic        RamWrite, RamRead, BusError;
    logic [31:0] PortOut;

    int       cyc = 0;
    int       total = 0;
    int       bad = 0;
    int       tag_n = 0;
    sb_item_t sb[$];
    sb_item_t it;
    logic [31:0] act;

    data_mem_io_bridge_if bus ();

    data_mem_io_bridge dut (
        .clk(clk), .reset(reset), .bus(bus), .PortIn(PortIn), .RamReadData(RamReadData),
        .RamAddress(RamAddress), .RamWrite(RamWrite), .RamRead(RamRead),
        .PortOut(PortOut), .BusError(BusError)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int s);
        case (s)
            0: return "ReadData";
            1: return "PortOut";
            2: return "BusError";
            3: return "RamWrite";
            4: return "RamRead";
            5: return "RamAddress";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation that belongs to the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            total++;
            case (it.sel)
                SEL_RD:  act = bus.ReadData;
                SEL_PO:  act = PortOut;
                SEL_BE:  act = {31'd0, BusError};
                SEL_RW:  act = {31'd0, RamWrite};
                SEL_RR:  act = {31'd0, RamRead};
                SEL_RA:  act = {22'd0, RamAddress};
                default: act = 32'hxxxx_xxxx;
            endcase
            if (it.cyc != cyc) begin
                bad++;
                $display("FAIL %s#%0d stale check: queued for cycle %0d, seen in %0d", sel_name(it.sel), it.tag, it.cyc, cyc);
            end else if (act !== it.exp) begin
                bad++;
                $display("FAIL %s#%0d got=%h expected=%h", sel_name(it.sel), it.tag, act, it.exp);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic r);
        bus.Address   = a;
        bus.WriteData = wd;
        bus.MemWrite  = w;
        bus.MemRead   = r;
    endtask

    task automatic idle();
        drive(32'h0000_0000, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic expect_v(input int sel, input logic [31:0] v);
        sb.push_back('{cyc, sel, v, tag_n});
        tag_n++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        PortIn      = 8'd0;
        RamReadData = 32'hCAFE_0001;
        idle();
        step();
        expect_v(SEL_PO, 32'd0);
        expect_v(SEL_BE, 32'd0);
        step();
        reset = 1'b0;

        // Reset values, idle read data.
        drive(IO + 32'h0C, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'hFFFF_FFFF); step();
        idle(); expect_v(SEL_RD, 32'd0); step();

        // Output port.
        drive(IO, 32'h0000_00A5, 1'b1, 1'b0); expect_v(SEL_RW, 32'd0); step();
        drive(IO, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'h0000_00A5); expect_v(SEL_PO, 32'h0000_00A5); step();

        // Input synchroniser latency.
        PortIn = 8'h3C;
        drive(IO + 32'h04, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd0); step();
        expect_v(SEL_RD, 32'd0); step();
        expect_v(SEL_RD, 32'h0000_003C); step();

        // Timer match.
        drive(IO + 32'h0C, 32'd5, 1'b1, 1'b0); step();
        drive(IO + 32'h08, 32'd0, 1'b1, 1'b0); step();
        drive(IO + 32'h10, 32'd1, 1'b1, 1'b0); step();
        for (int i = 0; i < 6; i++) begin
            drive(IO + 32'h08, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'(i)); step();
        end
        drive(IO + 32'h10, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd3); step();
        drive(IO + 32'h10, 32'd3, 1'b1, 1'b0); step();
        drive(IO + 32'h10, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd1); step();
        drive(IO + 32'h0C, 32'd12, 1'b1, 1'b0); step();
        drive(IO + 32'h10, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd1); step();
        drive(IO + 32'h08, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd11); step();
        drive(IO + 32'h10, 32'd3, 1'b1, 1'b0); step();
        drive(IO + 32'h10, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd3); step();
        drive(IO + 32'h10, 32'd0, 1'b1, 1'b0); step();
        drive(IO + 32'h10, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd2); step();

        // Counter wrap and write priority over increment.
        drive(IO + 32'h10, 32'd1, 1'b1, 1'b0); step();
        drive(IO + 32'h08, 32'hFFFF_FFFE, 1'b1, 1'b0); step();
        drive(IO + 32'h08, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'hFFFF_FFFE); step();
        expect_v(SEL_RD, 32'hFFFF_FFFF); step();
        expect_v(SEL_RD, 32'h0000_0000); step();
        expect_v(SEL_RD, 32'h0000_0001); step();

        // Unmapped I/O offsets and a legal RAM load; no error yet.
        drive(IO + 32'h14, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd0); step();
        drive(IO + 32'h1C, 32'h1234_5678, 1'b1, 1'b1); expect_v(SEL_RD, 32'd0); step();
        drive(32'h1001_0004, 32'd0, 1'b0, 1'b1);
        expect_v(SEL_RD, 32'hCAFE_0001); expect_v(SEL_RR, 32'd1); expect_v(SEL_RA, 32'd1); expect_v(SEL_BE, 32'd0); step();

        // Simultaneous read and write: write happens, old value returned.
        drive(IO, 32'h0000_0011, 1'b1, 1'b1); expect_v(SEL_RD, 32'h0000_00A5); expect_v(SEL_BE, 32'd0); step();
        idle(); expect_v(SEL_PO, 32'h0000_0011); step();

        // RAM store at the top word.
        drive(32'h1001_0FFC, 32'hDEAD_BEEF, 1'b1, 1'b0);
        expect_v(SEL_RW, 32'd1); expect_v(SEL_RA, 32'd1023); expect_v(SEL_RR, 32'd0); step();

        // Misaligned and unmapped accesses.
        drive(32'h1001_0002, 32'd0, 1'b0, 1'b1);
        expect_v(SEL_RR, 32'd0); expect_v(SEL_RD, 32'd0); expect_v(SEL_BE, 32'd0); step();
        drive(32'h2000_0000, 32'h5555_5555, 1'b1, 1'b0); expect_v(SEL_RW, 32'd0); expect_v(SEL_BE, 32'd1); step();
        idle(); expect_v(SEL_BE, 32'd1); step();
        drive(32'h1001_1000, 32'd0, 1'b0, 1'b1); expect_v(SEL_RR, 32'd0); expect_v(SEL_RD, 32'd0); step();
        idle(); expect_v(SEL_BE, 32'd1); step();

        // Reset overrides a concurrent write and increment.
        drive(IO, 32'h0000_0077, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(IO + 32'h04, 32'd0, 1'b0, 1'b1);
        expect_v(SEL_PO, 32'd0); expect_v(SEL_BE, 32'd0); expect_v(SEL_RD, 32'd0); step();
        drive(IO + 32'h0C, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'hFFFF_FFFF); step();
        drive(IO + 32'h08, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd0); step();
        drive(IO + 32'h10, 32'd0, 1'b0, 1'b1); expect_v(SEL_RD, 32'd0); step();
        idle();

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            bad++;
            total++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
